// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg: shared UART definitions (frame FSM encodings, size defaults).
// Also used by uart_rx; UART_TX_PARITY_EN enables the TX parity bit.
package uart_tx_pkg;

  localparam int UART_DATA_WIDTH = 8;
  localparam int UART_DIV_WIDTH  = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REQ    = 3'd1,
    ST_ACK    = 3'd2,
    ST_START  = 3'd3,
    ST_DATA   = 3'd4,
    ST_PARITY = 3'd5,
    ST_STOP   = 3'd6
  } uart_state_e;

  // Zero-extension is harmless: extra zeros do not change the XOR.
  function automatic logic frame_parity(
    input logic [15:0] data,
    input logic        odd
  );
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: loadable bit-period down-counter, tick when it reaches 0.
// Shared by the UART transmitter and receiver.
module uart_baud_gen #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 load_i,
  input  logic                 en_i,
  input  logic [DIV_WIDTH-1:0] div_i,
  output logic                 tick_o
);

  logic [DIV_WIDTH-1:0] cnt_q;
  logic [DIV_WIDTH-1:0] cnt_d;

  // Reload on terminal count so the counter never underflows.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = div_i;
    end else if (en_i) begin
      if (cnt_q == '0) begin
        cnt_d = div_i;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = (cnt_q == '0);

endmodule

// File: rtl/uart_tx.sv
// uart_tx: FIFO-fed UART serializer (start, LSB-first data, 1/2 stop bits).
// Define UART_TX_PARITY_EN to add the parity_odd port and a parity bit.
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = UART_DATA_WIDTH,
  parameter int DIV_WIDTH  = UART_DIV_WIDTH
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [DIV_WIDTH-1:0]  clk_div,
  input  logic                  stop2,
  input  logic                  fifo_empty,
  output logic                  fifo_read_enable,
  input  logic                  fifo_read_ack,
  input  logic [DATA_WIDTH-1:0] fifo_data,
`ifdef UART_TX_PARITY_EN
  input  logic                  parity_odd,
`endif
  output logic                  tx,
  output logic                  busy,
  output logic                  tx_done
);

  localparam int BW = $clog2(DATA_WIDTH);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

  uart_state_e           state_q;
  logic                  tx_q;
  logic                  rd_en_q;
  logic                  busy_q;
  logic                  done_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic [BW-1:0]         bit_q;
  logic                  stop_q;
  logic                  stop2_q;
  logic [DIV_WIDTH-1:0]  div_q;
`ifdef UART_TX_PARITY_EN
  logic                  par_q;
`endif

  logic                  baud_load;
  logic                  baud_en;
  logic [DIV_WIDTH-1:0]  baud_div;
  logic                  tick;

  // The first bit period uses the divisor being latched this cycle.
  assign baud_load = (state_q == ST_ACK) && fifo_read_ack;
  assign baud_div  = baud_load ? clk_div : div_q;
  assign baud_en   = (state_q == ST_START)  ||
                     (state_q == ST_DATA)   ||
                     (state_q == ST_PARITY) ||
                     (state_q == ST_STOP);

  uart_baud_gen #(
    .DIV_WIDTH(DIV_WIDTH)
  ) u_baud (
    .clk_i (clk),
    .rst_i (resetn),
    .load_i(baud_load),
    .en_i  (baud_en),
    .div_i (baud_div),
    .tick_o(tick)
  );

  always_ff @(posedge clk) begin
    if (resetn) begin
      state_q <= ST_IDLE;
      tx_q    <= 1'b1;
      rd_en_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      shift_q <= '0;
      bit_q   <= '0;
      stop_q  <= 1'b0;
      stop2_q <= 1'b0;
      div_q   <= '0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      rd_en_q <= 1'b0;
      done_q  <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          tx_q <= 1'b1;
          if (!fifo_empty) begin
            state_q <= ST_REQ;
            rd_en_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        ST_REQ: begin
          state_q <= ST_ACK;
        end
        ST_ACK: begin
          if (fifo_read_ack) begin
            shift_q <= fifo_data;
            div_q   <= clk_div;
            stop2_q <= stop2;
`ifdef UART_TX_PARITY_EN
            par_q   <= frame_parity(16'(fifo_data), parity_odd);
`endif
            bit_q   <= '0;
            stop_q  <= 1'b0;
            tx_q    <= 1'b0;
            state_q <= ST_START;
          end else begin
            // Entry vanished (flush) between sampling and the read.
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        ST_START: begin
          if (tick) begin
            tx_q    <= shift_q[0];
            state_q <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (tick) begin
            shift_q <= shift_q >> 1;
            if (bit_q == LAST_BIT) begin
              bit_q   <= '0;
`ifdef UART_TX_PARITY_EN
              tx_q    <= par_q;
              state_q <= ST_PARITY;
`else
              tx_q    <= 1'b1;
              state_q <= ST_STOP;
`endif
            end else begin
              bit_q <= bit_q + 1'b1;
              tx_q  <= shift_q[1];
            end
          end
        end
        ST_PARITY: begin
          if (tick) begin
            tx_q    <= 1'b1;
            state_q <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (tick) begin
            if (stop2_q && !stop_q) begin
              stop_q <= 1'b1;
            end else begin
              stop_q  <= 1'b0;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= ST_IDLE;
            end
          end
        end
        default: begin
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign tx               = tx_q;
  assign busy             = busy_q;
  assign tx_done          = done_q;
  assign fifo_read_enable = rd_en_q;

endmodule
